// File: rtl/noc_pkg.sv
// Shared definitions for mesh_xy_noc resource-side blocks: packet geometry,
// field offsets, injection modes and generator FSM states.
package noc_pkg;

  localparam int LFSR_W = 16;

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_RR    = 2'd1,
    MODE_RAND  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int src_w(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int seq_w(input int data_w, input int rows, input int cols);
    return data_w - src_w(rows, cols);
  endfunction

  function automatic int packet_w(input int data_w, input int rows, input int cols);
    return data_w + $clog2(rows) + $clog2(cols);
  endfunction

  // LSB positions of each field; layout MSB first is {row, col, src, seq}.
  function automatic int src_lsb(input int data_w, input int rows, input int cols);
    return seq_w(data_w, rows, cols);
  endfunction

  function automatic int col_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int row_lsb(input int data_w, input int cols);
    return data_w + $clog2(cols);
  endfunction

endpackage

// File: rtl/noc_lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, advancing one step per enabled cycle.
module noc_lfsr16
  import noc_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic [LFSR_W-1:0] lfsr_o
);

  logic [LFSR_W-1:0] r_lfsr;
  logic              w_fb;

  assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lfsr <= SEED;
    end else if (en_i) begin
      r_lfsr <= {r_lfsr[14:0], w_fb};
    end
  end

  assign lfsr_o = r_lfsr;

endmodule

// File: rtl/noc_rsc_traffic_node.sv
// Resource-side traffic generator and checker for one mesh_xy_noc node: injects
// single-word packets and checks address and per-source order of arrivals.
module noc_rsc_traffic_node
  import noc_pkg::*;
#(
  parameter int          ROW_N       = 3,
  parameter int          COL_M       = 3,
  parameter int          ROW_IDX     = 0,
  parameter int          COL_IDX     = 0,
  parameter int          PCKT_DATA_W = 8,
  parameter int          CNT_W       = 16,
  parameter int          GAP_W       = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic                                            en_i,
  input  logic [1:0]                                      mode_i,
  input  logic [$clog2(ROW_N)-1:0]                        dest_row_i,
  input  logic [$clog2(COL_M)-1:0]                        dest_col_i,
  input  logic [CNT_W-1:0]                                pckt_cnt_i,
  input  logic [GAP_W-1:0]                                gap_i,
  output logic [packet_w(PCKT_DATA_W, ROW_N, COL_M)-1:0]  rsc_pckt_o,
  output logic                                            rsc_wren_o,
  input  logic                                            noc_full_i,
  input  logic                                            noc_ovrflw_i,
  input  logic [packet_w(PCKT_DATA_W, ROW_N, COL_M)-1:0]  noc_pckt_i,
  input  logic                                            noc_wren_i,
  output logic                                            rsc_full_o,
  output logic                                            rsc_ovrflw_o,
  output logic [CNT_W-1:0]                                tx_cnt_o,
  output logic [CNT_W-1:0]                                rx_cnt_o,
  output logic [CNT_W-1:0]                                err_cnt_o,
  output logic [CNT_W-1:0]                                drop_cnt_o,
  output logic                                            busy_o,
  output logic                                            done_o
);

  // state | meaning
  // IDLE  | waiting for en_i; mode/destination/count/gap latched on exit
  // SEND  | issue one packet per cycle while noc_full_i is low
  // GAP   | idle cycles between injections, timed by a down-counter
  // DONE  | pckt_cnt packets sent; hold until en_i drops

  localparam int RW     = $clog2(ROW_N);
  localparam int CW     = $clog2(COL_M);
  localparam int SRC_W  = src_w(ROW_N, COL_M);
  localparam int SEQ_W  = seq_w(PCKT_DATA_W, ROW_N, COL_M);
  localparam int PKT_W  = packet_w(PCKT_DATA_W, ROW_N, COL_M);
  localparam int NSRC   = 1 << SRC_W;
  localparam logic [SRC_W-1:0] SRC_ID = SRC_W'(ROW_IDX * COL_M + COL_IDX);

  state_e             r_state;
  state_e             w_state_nxt;
  mode_e              r_mode;
  logic [RW-1:0]      r_dest_row;
  logic [CW-1:0]      r_dest_col;
  logic [CNT_W-1:0]   r_remaining;
  logic               r_unlim;
  logic [GAP_W-1:0]   r_gap;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [RW-1:0]      r_rr_row;
  logic [CW-1:0]      r_rr_col;
  logic [SEQ_W-1:0]   r_seq [NSRC];
  logic [SEQ_W-1:0]   r_exp [NSRC];

  logic [PKT_W-1:0]   r_pckt;
  logic               r_wren;
  logic [CNT_W-1:0]   r_tx;
  logic [CNT_W-1:0]   r_rx;
  logic [CNT_W-1:0]   r_err;
  logic [CNT_W-1:0]   r_drop;
  logic               r_busy;
  logic               r_done;

  logic               w_issue;
  logic               w_last;
  logic               w_lfsr_step;
  logic [LFSR_W-1:0]  w_lfsr;
  logic [RW-1:0]      w_dst_row;
  logic [CW-1:0]      w_dst_col;
  logic [SRC_W-1:0]   w_dst_idx;
  logic [PKT_W-1:0]   w_pckt;

  logic [RW-1:0]      w_rx_row;
  logic [CW-1:0]      w_rx_col;
  logic [SRC_W-1:0]   w_rx_src;
  logic [SEQ_W-1:0]   w_rx_seq;
  logic               w_rx_addr_bad;
  logic               w_rx_seq_bad;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_issue     = (r_state == ST_SEND) && en_i && !noc_full_i;
  assign w_last      = !r_unlim && (r_remaining == CNT_W'(1));
  assign w_lfsr_step = w_issue && (r_mode == MODE_RAND);

  noc_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (w_lfsr_step),
    .lfsr_o (w_lfsr)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (en_i) w_state_nxt = ST_SEND;
      ST_SEND: begin
        if (!en_i) begin
          w_state_nxt = ST_IDLE;
        end else if (w_issue) begin
          if (w_last)              w_state_nxt = ST_DONE;
          else if (r_gap != '0)    w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (!en_i)                 w_state_nxt = ST_IDLE;
        else if (r_gap_cnt == '0)  w_state_nxt = ST_SEND;
      end
      ST_DONE: if (!en_i) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_dst_row = r_dest_row;
    w_dst_col = r_dest_col;
    case (r_mode)
      MODE_RR: begin
        w_dst_row = r_rr_row;
        w_dst_col = r_rr_col;
      end
      MODE_RAND: begin
        w_dst_row = RW'(int'(w_lfsr[7:0]) % ROW_N);
        w_dst_col = CW'(int'(w_lfsr[15:8]) % COL_M);
      end
      default: ;
    endcase
  end

  assign w_dst_idx = SRC_W'(int'(w_dst_row) * COL_M + int'(w_dst_col));
  assign w_pckt    = {w_dst_row, w_dst_col, SRC_ID, r_seq[w_dst_idx]};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mode      <= MODE_FIXED;
      r_dest_row  <= '0;
      r_dest_col  <= '0;
      r_remaining <= '0;
      r_unlim     <= 1'b0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_rr_row    <= '0;
      r_rr_col    <= '0;
      r_pckt      <= '0;
      r_wren      <= 1'b0;
      r_tx        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      for (int i = 0; i < NSRC; i++) r_seq[i] <= '0;
    end else begin
      r_wren <= 1'b0;
      r_busy <= (w_state_nxt == ST_SEND) || (w_state_nxt == ST_GAP);
      // done_o trails the DONE entry by one cycle so it rises after the last strobe
      r_done <= (r_state == ST_DONE) && (w_state_nxt == ST_DONE);

      if ((r_state == ST_IDLE) && en_i) begin
        r_mode      <= mode_e'(mode_i);
        r_dest_row  <= dest_row_i;
        r_dest_col  <= dest_col_i;
        r_remaining <= pckt_cnt_i;
        r_unlim     <= (pckt_cnt_i == '0);
        r_gap       <= gap_i;
        r_rr_row    <= '0;
        r_rr_col    <= '0;
      end

      if (w_issue) begin
        r_wren             <= 1'b1;
        r_pckt             <= w_pckt;
        r_tx               <= sat_inc(r_tx);
        r_remaining        <= r_remaining - 1'b1;
        r_seq[w_dst_idx]   <= r_seq[w_dst_idx] + 1'b1;
        if (r_gap != '0) r_gap_cnt <= r_gap - 1'b1;
        if (r_mode == MODE_RR) begin
          if (r_rr_col == CW'(COL_M - 1)) begin
            r_rr_col <= '0;
            r_rr_row <= (r_rr_row == RW'(ROW_N - 1)) ? '0 : r_rr_row + 1'b1;
          end else begin
            r_rr_col <= r_rr_col + 1'b1;
          end
        end
      end else if ((r_state == ST_GAP) && (r_gap_cnt != '0)) begin
        r_gap_cnt <= r_gap_cnt - 1'b1;
      end
    end
  end

  assign w_rx_row      = noc_pckt_i[row_lsb(PCKT_DATA_W, COL_M) +: RW];
  assign w_rx_col      = noc_pckt_i[col_lsb(PCKT_DATA_W) +: CW];
  assign w_rx_src      = noc_pckt_i[src_lsb(PCKT_DATA_W, ROW_N, COL_M) +: SRC_W];
  assign w_rx_seq      = noc_pckt_i[SEQ_W-1:0];
  assign w_rx_addr_bad = (w_rx_row != RW'(ROW_IDX)) || (w_rx_col != CW'(COL_IDX));
  assign w_rx_seq_bad  = (w_rx_seq != r_exp[w_rx_src]);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rx   <= '0;
      r_err  <= '0;
      r_drop <= '0;
      for (int i = 0; i < NSRC; i++) r_exp[i] <= '0;
    end else begin
      if (noc_wren_i) begin
        r_rx <= sat_inc(r_rx);
        if (w_rx_addr_bad || w_rx_seq_bad) r_err <= sat_inc(r_err);
        r_exp[w_rx_src] <= w_rx_seq + 1'b1;
      end
      if (noc_ovrflw_i) r_drop <= sat_inc(r_drop);
    end
  end

  assign rsc_pckt_o   = r_pckt;
  assign rsc_wren_o   = r_wren;
  assign rsc_full_o   = 1'b0;
  assign rsc_ovrflw_o = 1'b0;
  assign tx_cnt_o     = r_tx;
  assign rx_cnt_o     = r_rx;
  assign err_cnt_o    = r_err;
  assign drop_cnt_o   = r_drop;
  assign busy_o       = r_busy;
  assign done_o       = r_done;

endmodule

// File: tb/tb_noc_rsc_traffic_node.sv
// Scoreboard bench for noc_rsc_traffic_node at node (0,0) of a 3x3 mesh.
module tb_noc_rsc_traffic_node;

  localparam int          ROW_N = 3;
  localparam int          COL_M = 3;
  localparam int          DW    = 8;
  localparam int          CNT_W = 16;
  localparam int          GAP_W = 8;
  localparam int          PKT_W = 12;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             en_i = 1'b0;
  logic [1:0]       mode_i = 2'd0;
  logic [1:0]       dest_row_i = 2'd0;
  logic [1:0]       dest_col_i = 2'd0;
  logic [CNT_W-1:0] pckt_cnt_i = '0;
  logic [GAP_W-1:0] gap_i = '0;
  logic [PKT_W-1:0] rsc_pckt_o;
  logic             rsc_wren_o;
  logic             noc_full_i = 1'b0;
  logic             noc_ovrflw_i = 1'b0;
  logic [PKT_W-1:0] noc_pckt_i = '0;
  logic             noc_wren_i = 1'b0;
  logic             rsc_full_o;
  logic             rsc_ovrflw_o;
  logic [CNT_W-1:0] tx_cnt_o, rx_cnt_o, err_cnt_o, drop_cnt_o;
  logic             busy_o, done_o;

  always #5 clk = ~clk;

  noc_rsc_traffic_node #(
    .ROW_N(ROW_N), .COL_M(COL_M), .ROW_IDX(0), .COL_IDX(0),
    .PCKT_DATA_W(DW), .CNT_W(CNT_W), .GAP_W(GAP_W), .LFSR_SEED(SEED)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .mode_i(mode_i),
    .dest_row_i(dest_row_i), .dest_col_i(dest_col_i), .pckt_cnt_i(pckt_cnt_i),
    .gap_i(gap_i), .rsc_pckt_o(rsc_pckt_o), .rsc_wren_o(rsc_wren_o),
    .noc_full_i(noc_full_i), .noc_ovrflw_i(noc_ovrflw_i), .noc_pckt_i(noc_pckt_i),
    .noc_wren_i(noc_wren_i), .rsc_full_o(rsc_full_o), .rsc_ovrflw_o(rsc_ovrflw_o),
    .tx_cnt_o(tx_cnt_o), .rx_cnt_o(rx_cnt_o), .err_cnt_o(err_cnt_o),
    .drop_cnt_o(drop_cnt_o), .busy_o(busy_o), .done_o(done_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit full_seen = 1'b0;
  int run_id = 0;
  int exp_gap = 0;
  bit chk_gap = 1'b0;
  int last_strobe_cyc = -1;
  logic [PKT_W-1:0] exp_q[$];

  // Reference model state
  int          m_seq [9];
  int          m_exp [16];
  logic [15:0] m_lfsr;
  int          m_rr;
  int          m_tx, m_rx, m_err, m_drop;

  task automatic chk(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [PKT_W-1:0] mk_pkt(input int r, input int c, input int s, input int q);
    logic [1:0] rr, cc;
    logic [3:0] ss, qq;
    rr = r[1:0];
    cc = c[1:0];
    ss = s[3:0];
    qq = q[3:0];
    return {rr, cc, ss, qq};
  endfunction

  task automatic model_reset();
    m_lfsr = SEED;
    m_rr   = 0;
    m_tx   = 0;
    m_rx   = 0;
    m_err  = 0;
    m_drop = 0;
    for (int i = 0; i < 9; i++) m_seq[i] = 0;
    for (int i = 0; i < 16; i++) m_exp[i] = 0;
  endtask

  task automatic model_issue(input int mode, input int fr, input int fc);
    int r, c, d;
    case (mode)
      1: begin
        r = m_rr / COL_M;
        c = m_rr % COL_M;
        m_rr = (m_rr + 1) % (ROW_N * COL_M);
      end
      2: begin
        r = m_lfsr[7:0] % ROW_N;
        c = m_lfsr[15:8] % COL_M;
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      end
      default: begin
        r = fr;
        c = fc;
      end
    endcase
    d = r * COL_M + c;
    exp_q.push_back(mk_pkt(r, c, 0, m_seq[d]));
    m_seq[d] = (m_seq[d] + 1) % 16;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      full_seen = noc_full_i;
    end
  end

  // Monitor: pops the scoreboard on every strobe
  initial begin
    int mon_run;
    int prev;
    logic [PKT_W-1:0] e;
    mon_run = -1;
    prev = -1;
    forever begin
      @(negedge clk);
      if (full_seen) chk(!rsc_wren_o, "stall_no_strobe", rsc_wren_o, 0);
      if (rsc_wren_o) begin
        chk(exp_q.size() != 0, "strobe_expected", exp_q.size(), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk(rsc_pckt_o === e, "tx_packet", rsc_pckt_o, e);
        end
        if (mon_run != run_id) begin
          mon_run = run_id;
          prev = -1;
        end
        if (chk_gap && prev >= 0) chk((cyc - prev) == exp_gap + 1, "strobe_spacing", cyc - prev, exp_gap + 1);
        prev = cyc;
        last_strobe_cyc = cyc;
      end
    end
  end

  task automatic start_run(input int mode, input int r, input int c, input int cnt, input int gap, input bit gapchk);
    int n;
    mode_i     = 2'(mode);
    dest_row_i = 2'(r);
    dest_col_i = 2'(c);
    pckt_cnt_i = CNT_W'(cnt);
    gap_i      = GAP_W'(gap);
    exp_gap    = gap;
    chk_gap    = gapchk;
    run_id++;
    m_rr = 0;
    exp_q.delete();
    n = (cnt == 0) ? 40 : cnt;
    for (int i = 0; i < n; i++) model_issue(mode, r, c);
    if (cnt != 0) m_tx += cnt;
    en_i = 1'b1;
    repeat (2) @(negedge clk);
    chk(rsc_wren_o == 1'b1, "first_strobe_latency", rsc_wren_o, 1);
    chk(busy_o == 1'b1, "busy_while_sending", busy_o, 1);
  endtask

  task automatic finish_run(input int budget);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(done_o == 1'b1, "done_timeout", done_o, 1);
    chk((cyc - last_strobe_cyc) == 1, "done_after_last", cyc - last_strobe_cyc, 1);
    chk(exp_q.size() == 0, "all_strobes_seen", exp_q.size(), 0);
    chk(tx_cnt_o == CNT_W'(m_tx), "tx_cnt", tx_cnt_o, m_tx);
    chk(busy_o == 1'b0, "busy_in_done", busy_o, 0);
    exp_q.delete();
    en_i = 1'b0;
    repeat (2) @(negedge clk);
    chk({done_o, busy_o} == 2'b00, "idle_after_disable", {done_o, busy_o}, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk(rsc_wren_o == 1'b0, {tag, "_wren"}, rsc_wren_o, 0);
    chk(rsc_pckt_o == '0, {tag, "_pckt"}, rsc_pckt_o, 0);
    chk(tx_cnt_o == '0, {tag, "_tx"}, tx_cnt_o, 0);
    chk(rx_cnt_o == '0, {tag, "_rx"}, rx_cnt_o, 0);
    chk(err_cnt_o == '0, {tag, "_err"}, err_cnt_o, 0);
    chk(drop_cnt_o == '0, {tag, "_drop"}, drop_cnt_o, 0);
    chk({busy_o, done_o} == 2'b00, {tag, "_status"}, {busy_o, done_o}, 0);
    chk({rsc_full_o, rsc_ovrflw_o} == 2'b00, {tag, "_backpressure"}, {rsc_full_o, rsc_ovrflw_o}, 0);
  endtask

  task automatic rx_send(input int r, input int c, input int src, input int sq);
    bit bad;
    noc_pckt_i = mk_pkt(r, c, src, sq);
    noc_wren_i = 1'b1;
    @(negedge clk);
    noc_wren_i = 1'b0;
    m_rx++;
    bad = (r != 0) || (c != 0) || (sq != m_exp[src]);
    if (bad) m_err++;
    m_exp[src] = (sq + 1) % 16;
    chk(rx_cnt_o == CNT_W'(m_rx), "rx_cnt", rx_cnt_o, m_rx);
    chk(err_cnt_o == CNT_W'(m_err), "err_cnt", err_cnt_o, m_err);
  endtask

  initial begin
    int r, c, cnt, gap, mode, sq, src, b;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    @(negedge clk);

    // Fixed destination (2,1), 4 packets, back to back
    start_run(0, 2, 1, 4, 0, 1'b1);
    finish_run(50);

    // Backpressure: noc_full_i held for 5 cycles mid-burst
    r = $urandom_range(0, 2);
    c = $urandom_range(0, 2);
    start_run(0, r, c, 8, 0, 1'b0);
    repeat (2) @(negedge clk);
    noc_full_i = 1'b1;
    repeat (5) @(negedge clk);
    noc_full_i = 1'b0;
    finish_run(60);

    // Randomised runs: random-mode and fixed/reserved-mode mixes
    for (int k = 0; k < 4; k++) begin
      cnt  = $urandom_range(3, 8);
      gap  = $urandom_range(0, 3);
      r    = $urandom_range(0, 2);
      c    = $urandom_range(0, 2);
      mode = (k % 2 == 0) ? 2 : (($urandom_range(0, 1) == 0) ? 0 : 3);
      start_run(mode, r, c, cnt, gap, 1'b1);
      finish_run(cnt * (gap + 1) + 20);
    end

    // Round-robin over the 3x3 mesh with gap 2
    start_run(1, 0, 0, 10, 2, 1'b1);
    finish_run(60);

    // Reset during an unlimited random burst
    start_run(2, 0, 0, 0, 0, 1'b0);
    repeat (8) @(negedge clk);
    rst_ni = 1'b0;
    en_i   = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrun_reset");
    rst_ni = 1'b1;
    exp_q.delete();
    model_reset();
    @(negedge clk);
    start_run(2, 0, 0, 6, 0, 1'b1);
    finish_run(40);

    // Receive path: sequence gap, misaddressed packet, then 4-bit seq wrap
    rx_send(0, 0, 4, 0);
    rx_send(0, 0, 4, 1);
    rx_send(0, 0, 4, 3);
    chk(err_cnt_o == 16'd1, "rx_seq_gap_err", err_cnt_o, 1);
    rx_send(1, 1, 4, 4);
    chk(err_cnt_o == 16'd2, "rx_addr_err", err_cnt_o, 2);
    for (int i = 0; i < 17; i++) rx_send(0, 0, 2, i % 16);
    chk(err_cnt_o == 16'd2, "rx_wrap_in_order", err_cnt_o, 2);

    for (int i = 0; i < 20; i++) begin
      src = $urandom_range(0, 8);
      r   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0;
      c   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : 0;
      sq  = ($urandom_range(0, 1) == 0) ? m_exp[src] : $urandom_range(0, 15);
      rx_send(r, c, src, sq);
    end

    // Overflow drops
    for (int i = 0; i < 30; i++) begin
      b = $urandom_range(0, 1);
      noc_ovrflw_i = b[0];
      m_drop += b;
      @(negedge clk);
    end
    noc_ovrflw_i = 1'b0;
    chk(drop_cnt_o == CNT_W'(m_drop), "drop_cnt", drop_cnt_o, m_drop);
    @(negedge clk);
    chk(drop_cnt_o == CNT_W'(m_drop), "drop_cnt_hold", drop_cnt_o, m_drop);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/noc_rsc_traffic_node.md
# noc_rsc_traffic_node

Parametrised resource-side traffic generator and checker for one node of the `mesh_xy_noc` mesh. It attaches to a node's resource channel in place of a real IP core. It injects single-word packets in fixed, round-robin or LFSR-random destination modes, and checks every packet the mesh delivers: destination address and per-source sequence order. One instance per node gives a self-checking NoC bench and a synthesizable on-chip stress test.

## Interface
- `ROW_N`, 3, mesh rows
- `COL_M`, 3, mesh columns
- `ROW_IDX`, 0, this node's row
- `COL_IDX`, 0, this node's column
- `PCKT_DATA_W`, 8, packet payload width; must be > `SRC_W` = $clog2(ROW_N*COL_M)
- `CNT_W`, 16, width of the statistics counters and of `pckt_cnt_i`
- `GAP_W`, 8, width of the inter-packet gap field
- `LFSR_SEED`, 16'hACE1, non-zero reset value of the 16-bit LFSR
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset; synchronous, active-low
- `en_i`  in  1  start/run
- `mode_i`  in  2  0 fixed, 1 round-robin, 2 random, 3 reserved (treated as fixed)
- `dest_row_i`  in  $clog2(ROW_N)  fixed-mode destination row
- `dest_col_i`  in  $clog2(COL_M)  fixed-mode destination column
- `pckt_cnt_i`  in  CNT_W  packets to send; 0 means unlimited
- `gap_i`  in  GAP_W  idle cycles between injections
- `rsc_pckt_o`  out  PACKET_W  packet toward the NoC
- `rsc_wren_o`  out  1  write strobe toward the NoC
- `noc_full_i`  in  1  NoC input FIFO full
- `noc_ovrflw_i`  in  1  NoC input FIFO overflow
- `noc_pckt_i`  in  PACKET_W  packet from the NoC
- `noc_wren_i`  in  1  write strobe from the NoC
- `rsc_full_o`  out  1  constant 0; the node always accepts
- `rsc_ovrflw_o`  out  1  constant 0
- `tx_cnt_o`, `rx_cnt_o`, `err_cnt_o`, `drop_cnt_o`  out  CNT_W  saturating statistics
- `busy_o`, `done_o`  out  1  generator status

## Operation
- PACKET_W = PCKT_DATA_W + $clog2(ROW_N) + $clog2(COL_M).
- Packet layout, MSB first: {dest_row, dest_col, src_id[SRC_W], seq[PCKT_DATA_W-SRC_W]}.
- src_id = ROW_IDX*COL_M + COL_IDX.
- seq is a per-destination counter that wraps modulo 2^(PCKT_DATA_W-SRC_W).
- FSM states: IDLE, SEND, GAP, DONE.
  - IDLE -> SEND when en_i=1. Mode, destination, pckt_cnt_i and gap_i are latched on this transition.
  - SEND: a packet is issued when noc_full_i=0. If noc_full_i=1, the FSM holds with nothing issued.
  - After an issue: -> DONE if tx_cnt reaches a non-zero pckt_cnt; else -> GAP if gap≠0; else stay in SEND.
  - GAP: counts gap cycles, then -> SEND.
  - en_i=0 in SEND or GAP -> IDLE; a packet already registered still completes.
  - DONE -> IDLE when en_i=0.
- Destination selection:
  - fixed: uses the latched dest_row/dest_col.
  - round-robin: row-major index 0..N-1, wrapping after N-1, starting at 0.
  - random: LFSR (x^16+x^14+x^13+x^11+1) steps once per issue. dest_row = lfsr[7:0] % ROW_N, dest_col = lfsr[15:8] % COL_M. Self-destination is allowed.
- Receive path, for each noc_wren_i=1:
  - rx_cnt increments.
  - err_cnt increments if the address ≠ (ROW_IDX, COL_IDX).
  - err_cnt increments if seq ≠ expected[src_id].
  - expected[src_id] is then set to seq+1.
  - A single packet adds at most 1 to err_cnt.
- drop_cnt increments on every cycle with noc_ovrflw_i=1.
- All counters saturate at 2^CNT_W-1.

## Timing
- Reset values: rsc_wren_o=0, rsc_pckt_o=0, all counters 0, busy_o=0, done_o=0, state IDLE, LFSR=LFSR_SEED, round-robin index 0, seq and expected arrays 0.
- All outputs are registered.
- Issue timing: rsc_wren_o and rsc_pckt_o are high/valid the cycle after SEND samples noc_full_i=0. The strobe lasts one cycle per packet.
- Sustained rate: one packet per cycle with gap=0; otherwise one per gap+1 cycles.
- en_i to first strobe: 2 cycles (IDLE->SEND, then the registered issue).
- tx_cnt_o updates in the same cycle as the strobe.
- done_o rises in the cycle after the last strobe. busy_o = (state ≠ IDLE && state ≠ DONE).
- Receive counters update 1 cycle after noc_wren_i.
- rst_ni low mid-run returns every register to its reset value at the next clock edge.

## Structure
- A shared package `noc_pkg` holds the packet-width function, the field-offset constants, the mode enum and the FSM state typedef. `mesh_xy_noc` benches reuse it.
- One sub-module, `noc_lfsr16`: enable, seed parameter, 16-bit state output.

## Test plan
- Fixed mode to (2,1), pckt_cnt=4, gap=0, full=0: exactly 4 consecutive strobes with seq 0..3 and src_id 0; done_o high 1 cycle after the 4th strobe; tx_cnt_o=4.
- noc_full_i held high for 5 cycles mid-burst: no strobes during the stall; resumes with the next seq value, none lost or duplicated.
- Round-robin, 3×3 mesh, pckt_cnt=10, gap=2: destinations 0..8 then 0; strobes spaced 3 cycles apart.
- RX: inject 3 packets addressed to self from src 4 with seq 0,1,3: rx_cnt_o=3, err_cnt_o=1. A 4th packet addressed to (1,1) at node (0,0): err_cnt_o=2.
- Wrap: with PCKT_DATA_W=8 and 9 nodes (SRC_W=4, 4-bit seq), 17 packets from one source: seq 15 then 0 accepted as in-order; err_cnt_o=0.
- rst_ni low during a random-mode burst: the next cycle shows all outputs at reset values; after re-enable the LFSR sequence repeats from LFSR_SEED.
